hpdcache_data_downsize_var: RTL and testbench

- Multi-entry downsizing buffer with a variable word count per entry.
- Accepts wide WR_WIDTH writes and returns them as a stream of RD_WIDTH words.
- Each written entry carries its own length, so only the valid words are returned.
- Provides a selectable word order, a last-word marker, an occupancy output and a synchronous flush. Sits between wide refill/read-data paths and narrow memory or core interfaces in the cache subsystem.

---
 rtl/hpdcache_data_downsize_var.sv | 112 +++++++++++
 tb/tb_hpdcache_data_downsize_var.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_data_downsize_var.sv
// Downsizing buffer: stores wide entries with a per-entry word count and
// streams them back as narrow words, last word of each entry flagged.
module hpdcache_data_downsize_var #(
  parameter int unsigned WR_WIDTH = 512,
  parameter int unsigned RD_WIDTH = 64,
  parameter int unsigned DEPTH    = 2,
  parameter bit          HI_FIRST = 1'b0,
  localparam int unsigned RD_WORDS = WR_WIDTH / RD_WIDTH,
  localparam int unsigned LEN_W    = (RD_WORDS > 1) ? $clog2(RD_WORDS) : 1,
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                w_i,
  output logic                wok_o,
  input  logic [WR_WIDTH-1:0] wdata_i,
  input  logic [LEN_W-1:0]    wlen_i,
  input  logic                r_i,
  output logic                rok_o,
  output logic [RD_WIDTH-1:0] rdata_o,
  output logic                rlast_o,
  output logic [PTR_W:0]      used_o
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(RD_WORDS - 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  logic [WR_WIDTH-1:0] r_buf [DEPTH];
  logic [LEN_W-1:0]    r_len [DEPTH];
  logic [PTR_W-1:0]    r_rdptr;
  logic [PTR_W-1:0]    r_wrptr;
  logic [PTR_W:0]      r_used;
  logic [LEN_W-1:0]    r_rcnt;

  logic                w_full;
  logic                w_empty;
  logic                w_wr;
  logic                w_rd;
  logic                w_pop;
  logic [LEN_W-1:0]    w_idx;
  logic [LEN_W-1:0]    w_wlen;
  logic [WR_WIDTH-1:0] w_head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_used == (PTR_W+1)'(DEPTH));
  assign w_empty = (r_used == '0);

  assign wok_o = ~w_full & ~flush_i;
  assign rok_o = ~w_empty & ~flush_i;

  assign w_wr  = w_i & wok_o;
  assign w_rd  = r_i & rok_o;
  assign w_pop = w_rd & rlast_o;

  // Clamp covers non-power-of-two word counts; single-word entries ignore wlen_i.
  always_comb begin
    w_wlen = wlen_i;
    if (RD_WORDS == 1) begin
      w_wlen = '0;
    end else if (wlen_i > LEN_MAX) begin
      w_wlen = LEN_MAX;
    end
  end

  assign w_idx   = HI_FIRST ? (LEN_MAX - r_rcnt) : r_rcnt;
  assign w_head  = r_buf[r_rdptr];
  assign rdata_o = w_head[w_idx*RD_WIDTH +: RD_WIDTH];
  assign rlast_o = rok_o & (r_rcnt == r_len[r_rdptr]);
  assign used_o  = r_used;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rdptr <= '0;
      r_wrptr <= '0;
      r_used  <= '0;
      r_rcnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
        r_len[i] <= '0;
      end
    end else if (flush_i) begin
      r_rdptr <= '0;
      r_wrptr <= '0;
      r_used  <= '0;
      r_rcnt  <= '0;
    end else begin
      if (w_wr) begin
        r_buf[r_wrptr] <= wdata_i;
        r_len[r_wrptr] <= w_wlen;
        r_wrptr        <= next_ptr(r_wrptr);
      end
      if (w_rd) begin
        if (rlast_o) begin
          r_rcnt  <= '0;
          r_rdptr <= next_ptr(r_rdptr);
        end else begin
          r_rcnt <= r_rcnt + 1'b1;
        end
      end
      case ({w_wr, w_pop})
        2'b10:   r_used <= r_used + 1'b1;
        2'b01:   r_used <= r_used - 1'b1;
        default: r_used <= r_used;
      endcase
    end
  end

endmodule

// File: tb/tb_hpdcache_data_downsize_var.sv
// Bench: two instances (DEPTH=2/LSB-first and DEPTH=3/MSB-first) share stimulus;
// each is compared every cycle against a FIFO-of-entries model.
module tb_hpdcache_data_downsize_var;

  logic         clk = 1'b0;
  logic         t_rs = 1'b0;
  logic         t_fl = 1'b0;
  logic         t_w = 1'b0;
  logic         t_r = 1'b0;
  logic [255:0] t_d = '0;
  logic [1:0]   t_wl = '0;

  logic        wok0, rok0, rlast0, wok1, rok1, rlast1;
  logic [63:0] rdata0, rdata1;
  logic [1:0]  used0;
  logic [2:0]  used1;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  hpdcache_data_downsize_var #(.WR_WIDTH(256), .RD_WIDTH(64), .DEPTH(2), .HI_FIRST(1'b0)) u0 (
    .clk_i(clk), .rst_ni(t_rs), .flush_i(t_fl), .w_i(t_w), .wok_o(wok0), .wdata_i(t_d),
    .wlen_i(t_wl), .r_i(t_r), .rok_o(rok0), .rdata_o(rdata0), .rlast_o(rlast0), .used_o(used0));

  hpdcache_data_downsize_var #(.WR_WIDTH(256), .RD_WIDTH(64), .DEPTH(3), .HI_FIRST(1'b1)) u1 (
    .clk_i(clk), .rst_ni(t_rs), .flush_i(t_fl), .w_i(t_w), .wok_o(wok1), .wdata_i(t_d),
    .wlen_i(t_wl), .r_i(t_r), .rok_o(rok1), .rdata_o(rdata1), .rlast_o(rlast1), .used_o(used1));

  // Model: ring of 4 slots per instance, holding whole entries and their word counts.
  logic [255:0] md [2][4];
  int           ml [2][4];
  int           mhead [2] = '{0, 0};
  int           mcnt  [2] = '{0, 0};
  int           mrcnt [2] = '{0, 0};
  int           mdepth [2] = '{2, 3};
  int           mhi    [2] = '{0, 1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    logic [63:0] a_rdata, e_rdata;
    logic        a_wok, a_rok, a_rlast, e_rok, e_rlast;
    int          a_used, idx;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        a_wok = wok0; a_rok = rok0; a_rlast = rlast0; a_rdata = rdata0; a_used = int'(used0);
      end else begin
        a_wok = wok1; a_rok = rok1; a_rlast = rlast1; a_rdata = rdata1; a_used = int'(used1);
      end
      e_rok   = (mcnt[k] > 0) && !t_fl;
      e_rlast = e_rok && (mrcnt[k] == ml[k][mhead[k]]);
      idx     = mhi[k] ? 3 - mrcnt[k] : mrcnt[k];
      e_rdata = md[k][mhead[k]][idx*64 +: 64];
      chk($sformatf("wok%0d", k), 64'(a_wok), 64'((mcnt[k] < mdepth[k]) && !t_fl));
      chk($sformatf("rok%0d", k), 64'(a_rok), 64'(e_rok));
      chk($sformatf("rlast%0d", k), 64'(a_rlast), 64'(e_rlast));
      chk($sformatf("used%0d", k), 64'(a_used), 64'(mcnt[k]));
      if (e_rok) chk($sformatf("rdata%0d", k), a_rdata, e_rdata);
    end
  endtask

  task automatic model_step();
    bit rd, wr;
    for (int k = 0; k < 2; k++) begin
      if (!t_rs || t_fl) begin
        mhead[k] = 0; mcnt[k] = 0; mrcnt[k] = 0;
      end else begin
        rd = t_r && (mcnt[k] > 0);
        wr = t_w && (mcnt[k] < mdepth[k]);
        if (rd) begin
          if (mrcnt[k] == ml[k][mhead[k]]) begin
            mhead[k] = (mhead[k] + 1) % 4;
            mcnt[k]--;
            mrcnt[k] = 0;
          end else begin
            mrcnt[k]++;
          end
        end
        if (wr) begin
          md[k][(mhead[k] + mcnt[k]) % 4] = t_d;
          ml[k][(mhead[k] + mcnt[k]) % 4] = int'(t_wl);
          mcnt[k]++;
        end
      end
    end
  endtask

  task automatic drive(input bit rs, input bit fl, input bit w, input logic [255:0] d,
                       input logic [1:0] wl, input bit r);
    @(negedge clk);
    t_rs = rs; t_fl = fl; t_w = w; t_d = d; t_wl = wl; t_r = r;
    #1;
    if (cmp_en) compare_model();
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
  endtask

  task automatic cyc(input bit rs, input bit fl, input bit w, input logic [255:0] d,
                     input logic [1:0] wl, input bit r);
    drive(rs, fl, w, d, wl, r);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 24 && (mcnt[0] > 0 || mcnt[1] > 0); i++) cyc(1, 0, 0, '0, 0, 1);
    chk("drain_empty", 64'(mcnt[0] + mcnt[1]), 64'd0);
  endtask

  localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] W4 = 64'h4444_4444_4444_4444;

  initial begin
    logic [255:0] dat, dat2;
    logic [63:0]  exp0 [4];
    logic [63:0]  exp1 [4];
    dat = {W4, W3, W2, W1};
    exp0 = '{W1, W2, W3, W4};
    exp1 = '{W4, W3, W2, W1};

    cyc(0, 0, 0, '0, 0, 0);
    cmp_en = 1'b1;
    cyc(0, 0, 0, '0, 0, 0);
    drive(1, 0, 0, '0, 0, 0);
    chk("rst_wok", 64'(wok0), 64'd1);
    chk("rst_rok", 64'(rok0), 64'd0);
    chk("rst_rlast", 64'(rlast0), 64'd0);
    chk("rst_used", 64'(used0), 64'd0);
    chk("rst_rdata", rdata0, 64'd0);
    step();

    // Full-length entry, both word orders.
    cyc(1, 0, 1, dat, 2'd3, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, '0, 0, 1);
      chk($sformatf("full_rd0_%0d", i), rdata0, exp0[i]);
      chk($sformatf("full_rd1_%0d", i), rdata1, exp1[i]);
      chk($sformatf("full_last_%0d", i), 64'(rlast0), 64'(i == 3));
      chk($sformatf("full_used_%0d", i), 64'(used0), 64'd1);
      step();
    end
    drive(1, 0, 0, '0, 0, 0);
    chk("full_used_after", 64'(used0), 64'd0);
    step();

    // Partial length: MSB-first instance returns words 3 then 2.
    cyc(1, 0, 1, dat, 2'd1, 0);
    drive(1, 0, 0, '0, 0, 1);
    chk("part_rd1_a", rdata1, W4);
    chk("part_last_a", 64'(rlast1), 64'd0);
    step();
    drive(1, 0, 0, '0, 0, 1);
    chk("part_rd1_b", rdata1, W3);
    chk("part_last_b", 64'(rlast1), 64'd1);
    chk("part_rd0_b", rdata0, W2);
    step();
    drive(1, 0, 0, '0, 0, 0);
    chk("part_used1", 64'(used1), 64'd0);
    step();

    // Back-pressure: a pop of the last word does not open the write port in that cycle.
    cyc(1, 0, 1, dat, 2'd1, 0);
    cyc(1, 0, 1, ~dat, 2'd0, 0);
    drive(1, 0, 1, {4{64'hC0C0}}, 2'd0, 1);
    chk("bp_wok", 64'(wok0), 64'd0);
    chk("bp_used", 64'(used0), 64'd2);
    step();
    drive(1, 0, 1, {4{64'hC0C0}}, 2'd0, 1);
    chk("bp_last", 64'(rlast0), 64'd1);
    chk("bp_wok_pop", 64'(wok0), 64'd0);
    step();
    drive(1, 0, 1, {4{64'hC0C0}}, 2'd0, 0);
    chk("bp_wok_next", 64'(wok0), 64'd1);
    chk("bp_used_next", 64'(used0), 64'd1);
    step();
    drain();

    // Write and last-word pop in the same cycle at used=1.
    dat2 = {W1, W2, W3, W4};
    cyc(1, 0, 1, dat, 2'd0, 0);
    drive(1, 0, 1, dat2, 2'd2, 1);
    chk("sim_last", 64'(rlast0), 64'd1);
    step();
    drive(1, 0, 0, '0, 0, 0);
    chk("sim_used", 64'(used0), 64'd1);
    chk("sim_rd0", rdata0, W4);
    chk("sim_rd1", rdata1, W1);
    chk("sim_nolast", 64'(rlast0), 64'd0);
    step();
    drain();

    // Flush mid-entry drops the entry and the concurrent write.
    cyc(1, 0, 1, dat, 2'd3, 0);
    cyc(1, 0, 0, '0, 0, 1);
    cyc(1, 0, 0, '0, 0, 1);
    drive(1, 1, 1, dat2, 2'd3, 1);
    chk("fl_wok", 64'(wok0), 64'd0);
    chk("fl_rok", 64'(rok0), 64'd0);
    step();
    drive(1, 0, 0, '0, 0, 0);
    chk("fl_used", 64'(used0), 64'd0);
    chk("fl_rok_after", 64'(rok0), 64'd0);
    step();

    // Reset mid-entry.
    cyc(1, 0, 1, dat, 2'd3, 0);
    cyc(1, 0, 0, '0, 0, 1);
    cyc(1, 0, 0, '0, 0, 1);
    cyc(0, 0, 1, dat2, 2'd3, 1);
    drive(1, 0, 0, '0, 0, 0);
    chk("mr_wok", 64'(wok0), 64'd1);
    chk("mr_rok", 64'(rok0), 64'd0);
    chk("mr_rlast", 64'(rlast0), 64'd0);
    chk("mr_used", 64'(used0), 64'd0);
    chk("mr_rdata", rdata0, 64'd0);
    step();

    // Random traffic with continuous-ish reads; model covers pointer wrap.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 1) == 1),
          {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
          2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
